// File: rtl/gpio_port_ctrl_if.sv
// Core-side register bus of the GPIO port: write strobes/ops, read strobe,
// interrupt clear and the readback values presented to the file-register decode.
interface gpio_port_ctrl_if #(
   parameter int WIDTH = 5
);
   logic             wr_port;
   logic             wr_tris;
   logic [1:0]       wr_op;
   logic [WIDTH-1:0] wr_data;
   logic             rd_port;
   logic             ioc_clr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] port_q;
   logic [WIDTH-1:0] tris_q;
   logic             ioc_flag;

   modport master (
      output wr_port, wr_tris, wr_op, wr_data, rd_port, ioc_clr,
      input  rd_data, port_q, tris_q, ioc_flag
   );

   modport slave (
      input  wr_port, wr_tris, wr_op, wr_data, rd_port, ioc_clr,
      output rd_data, port_q, tris_q, ioc_flag
   );
endinterface

// File: rtl/gpio_port_ctrl.sv
// Bidirectional GPIO port: output latch with bit ops, TRIS direction register,
// open-drain pins, input synchroniser and sticky interrupt-on-change flag.
module gpio_port_ctrl #(
   parameter int               WIDTH       = 5,
   parameter logic [31:0]      OD_MASK     = 32'b10000,
   parameter logic [31:0]      IOC_MASK    = 32'b00000,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] TRIS_RST    = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   gpio_port_ctrl_if.slave  bus,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe
);
   localparam logic [WIDTH-1:0] OD_M  = WIDTH'(OD_MASK);
   localparam logic [WIDTH-1:0] IOC_M = WIDTH'(IOC_MASK);

   logic [WIDTH-1:0] port_reg, port_next;
   logic [WIDTH-1:0] tris_reg;
   logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] snap_reg;
   logic             armed_reg;
   logic             flag_reg, flag_next;
   logic             mismatch;

   always_comb begin
      port_next = port_reg;
      if (bus.wr_port) begin
         case (bus.wr_op)
            2'b00:   port_next = bus.wr_data;
            2'b01:   port_next = port_reg | bus.wr_data;
            2'b10:   port_next = port_reg & ~bus.wr_data;
            default: port_next = port_reg ^ bus.wr_data;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         port_reg <= '0;
         tris_reg <= TRIS_RST;
      end else begin
         port_reg <= port_next;
         if (bus.wr_tris)
            tris_reg <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_reg[i] <= '0;
      end else begin
         sync_reg[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_reg[i] <= sync_reg[i-1];
      end
   end

   assign sync_q = sync_reg[SYNC_STAGES-1];

   // Mismatch uses the pre-edge snapshot, so a simultaneous rd_port cannot mask it.
   assign mismatch = armed_reg & (|(IOC_M & tris_reg & (sync_q ^ snap_reg)));

   always_comb begin
      flag_next = flag_reg;
      if (mismatch)
         flag_next = 1'b1;
      else if (bus.ioc_clr)
         flag_next = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_reg  <= '0;
         armed_reg <= 1'b0;
         flag_reg  <= 1'b0;
      end else begin
         flag_reg <= flag_next;
         if (bus.rd_port) begin
            snap_reg  <= sync_q;
            armed_reg <= 1'b1;
         end
      end
   end

   // Open-drain bits only ever pull low: a latched 1 releases the pad.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
         if (OD_M[gi]) begin : g_od
            assign pin_out[gi] = 1'b0;
            assign pin_oe[gi]  = ~tris_reg[gi] & ~port_reg[gi];
         end else begin : g_pp
            assign pin_out[gi] = port_reg[gi];
            assign pin_oe[gi]  = ~tris_reg[gi];
         end
      end
   endgenerate

   assign bus.rd_data  = sync_q;
   assign bus.port_q   = port_reg;
   assign bus.tris_q   = tris_reg;
   assign bus.ioc_flag = flag_reg;
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl: default 5-bit port with IOC on pins 3/4,
// a 3-stage synchroniser variant and an 8-bit push-pull loopback variant.
module tb_gpio_port_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   gpio_port_ctrl_if #(.WIDTH(5)) bus_a ();
   gpio_port_ctrl_if #(.WIDTH(5)) bus_c ();
   gpio_port_ctrl_if #(.WIDTH(8)) bus_w ();

   logic [4:0] pin_a, pout_a, poe_a;
   logic [4:0] pin_c, pout_c, poe_c;
   logic [7:0] pout_w, poe_w;

   gpio_port_ctrl #(.WIDTH(5), .IOC_MASK(32'h18)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave),
      .pin_in(pin_a), .pin_out(pout_a), .pin_oe(poe_a)
   );

   gpio_port_ctrl #(.WIDTH(5), .SYNC_STAGES(3)) dut_c (
      .clk(clk), .rst(rst), .bus(bus_c.slave),
      .pin_in(pin_c), .pin_out(pout_c), .pin_oe(poe_c)
   );

   gpio_port_ctrl #(.WIDTH(8), .OD_MASK(32'h0)) dut_w (
      .clk(clk), .rst(rst), .bus(bus_w.slave),
      .pin_in(pout_w), .pin_out(pout_w), .pin_oe(poe_w)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      total++; if (bus_a.port_q !== 5'h00) begin bad++; $display("FAIL rst_port got=%h exp=00", bus_a.port_q); end
      total++; if (bus_a.tris_q !== 5'h1F) begin bad++; $display("FAIL rst_tris got=%h exp=1f", bus_a.tris_q); end
      total++; if (poe_a !== 5'h00 || pout_a !== 5'h00) begin bad++; $display("FAIL rst_pad got oe=%h out=%h exp 00/00", poe_a, pout_a); end
      total++; if (bus_a.ioc_flag !== 1'b0 || bus_a.rd_data !== 5'h00) begin bad++; $display("FAIL rst_ioc got flag=%b rd=%h exp 0/00", bus_a.ioc_flag, bus_a.rd_data); end
      $display("reset: port=%h tris=%h oe=%h", bus_a.port_q, bus_a.tris_q, poe_a);

      bus_a.wr_tris = 1'b1; bus_a.wr_data = 5'h00; tick(); bus_a.wr_tris = 1'b0;
      bus_a.wr_port = 1'b1; bus_a.wr_op = 2'b00; bus_a.wr_data = 5'h1F; tick(); bus_a.wr_port = 1'b0;
      total++; if (bus_a.port_q !== 5'h1F) begin bad++; $display("FAIL pre_rst_port got=%h exp=1f", bus_a.port_q); end
      #2 rst = 1'b1;
      #1;
      total++; if (bus_a.port_q !== 5'h00 || bus_a.tris_q !== 5'h1F || poe_a !== 5'h00) begin
         bad++; $display("FAIL async_rst got port=%h tris=%h oe=%h exp 00/1f/00", bus_a.port_q, bus_a.tris_q, poe_a);
      end
      $display("async reset: port=%h tris=%h oe=%h", bus_a.port_q, bus_a.tris_q, poe_a);
      #2 rst = 1'b0;

      bus_a.wr_tris = 1'b1; bus_a.wr_data = 5'h00; tick(); bus_a.wr_tris = 1'b0;
      bus_a.wr_port = 1'b1; bus_a.wr_op = 2'b00; bus_a.wr_data = 5'h15; tick(); bus_a.wr_port = 1'b0;
      total++; if (pout_a !== 5'h05 || poe_a !== 5'h0F) begin bad++; $display("FAIL od_release got out=%h oe=%h exp 05/0f", pout_a, poe_a); end
      $display("write 15: out=%h oe=%h", pout_a, poe_a);
      bus_a.wr_port = 1'b1; bus_a.wr_op = 2'b00; bus_a.wr_data = 5'h05; tick(); bus_a.wr_port = 1'b0;
      total++; if (pout_a !== 5'h05 || poe_a !== 5'h1F) begin bad++; $display("FAIL od_drive got out=%h oe=%h exp 05/1f", pout_a, poe_a); end
      $display("write 05: out=%h oe=%h", pout_a, poe_a);
   endtask

   task automatic test_bit_ops();
      logic [1:0] ops [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [4:0] dat [4]  = '{5'h0A, 5'h01, 5'h08, 5'h1F};
      logic [4:0] exp_q [4] = '{5'h0A, 5'h0B, 5'h03, 5'h1C};
      for (int i = 0; i < 4; i++) begin
         bus_a.wr_port = 1'b1; bus_a.wr_op = ops[i]; bus_a.wr_data = dat[i];
         tick();
         bus_a.wr_port = 1'b0;
         total++; if (bus_a.port_q !== exp_q[i]) begin bad++; $display("FAIL bitop%0d got=%h exp=%h", i, bus_a.port_q, exp_q[i]); end
         $display("op=%b data=%h -> port=%h", ops[i], dat[i], bus_a.port_q);
      end
      bus_a.wr_port = 1'b1; bus_a.wr_tris = 1'b1; bus_a.wr_op = 2'b01; bus_a.wr_data = 5'h03;
      tick();
      bus_a.wr_port = 1'b0; bus_a.wr_tris = 1'b0;
      total++; if (bus_a.port_q !== 5'h1F || bus_a.tris_q !== 5'h03) begin
         bad++; $display("FAIL same_cycle got port=%h tris=%h exp 1f/03", bus_a.port_q, bus_a.tris_q);
      end
      $display("port+tris same edge: port=%h tris=%h", bus_a.port_q, bus_a.tris_q);
   endtask

   task automatic test_sync();
      pin_a = 5'h11; pin_c = 5'h11;
      tick();
      total++; if (bus_a.rd_data !== 5'h00 || bus_c.rd_data !== 5'h00) begin bad++; $display("FAIL sync_e1 got a=%h c=%h exp 00/00", bus_a.rd_data, bus_c.rd_data); end
      tick();
      total++; if (bus_a.rd_data !== 5'h11) begin bad++; $display("FAIL sync2_e2 got=%h exp=11", bus_a.rd_data); end
      total++; if (bus_c.rd_data !== 5'h00) begin bad++; $display("FAIL sync3_e2 got=%h exp=00", bus_c.rd_data); end
      tick();
      total++; if (bus_c.rd_data !== 5'h11) begin bad++; $display("FAIL sync3_e3 got=%h exp=11", bus_c.rd_data); end
      $display("sync: rd2=%h rd3=%h", bus_a.rd_data, bus_c.rd_data);
   endtask

   task automatic test_ioc();
      pin_a = 5'h00;
      rst = 1'b1; tick(); rst = 1'b0;
      pin_a = 5'h08;
      repeat (4) tick();
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_unarmed got=%b exp=0", bus_a.ioc_flag); end
      bus_a.rd_port = 1'b1; tick(); bus_a.rd_port = 1'b0;
      pin_a = 5'h00;
      tick(); tick();
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_early got=%b exp=0", bus_a.ioc_flag); end
      tick();
      total++; if (bus_a.ioc_flag !== 1'b1) begin bad++; $display("FAIL ioc_set got=%b exp=1", bus_a.ioc_flag); end
      $display("ioc pin3 toggle: flag=%b", bus_a.ioc_flag);

      bus_a.ioc_clr = 1'b1; tick(); bus_a.ioc_clr = 1'b0;
      total++; if (bus_a.ioc_flag !== 1'b1) begin bad++; $display("FAIL ioc_set_wins got=%b exp=1", bus_a.ioc_flag); end
      bus_a.rd_port = 1'b1; bus_a.ioc_clr = 1'b1; tick(); bus_a.rd_port = 1'b0; bus_a.ioc_clr = 1'b0;
      total++; if (bus_a.ioc_flag !== 1'b1) begin bad++; $display("FAIL ioc_rd_clr got=%b exp=1", bus_a.ioc_flag); end
      bus_a.ioc_clr = 1'b1; tick(); bus_a.ioc_clr = 1'b0;
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_clr got=%b exp=0", bus_a.ioc_flag); end
      tick();
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_stay_clr got=%b exp=0", bus_a.ioc_flag); end
      $display("ioc race/clear: flag=%b", bus_a.ioc_flag);

      pin_a = 5'h01;
      repeat (4) tick();
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_pin0 got=%b exp=0", bus_a.ioc_flag); end
      bus_a.wr_tris = 1'b1; bus_a.wr_data = 5'h17; tick(); bus_a.wr_tris = 1'b0;
      pin_a = 5'h09;
      repeat (4) tick();
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_output_pin got=%b exp=0", bus_a.ioc_flag); end
      bus_a.wr_tris = 1'b1; bus_a.wr_data = 5'h1F; tick(); bus_a.wr_tris = 1'b0;
      total++; if (bus_a.ioc_flag !== 1'b0) begin bad++; $display("FAIL ioc_tris_edge got=%b exp=0", bus_a.ioc_flag); end
      tick();
      total++; if (bus_a.ioc_flag !== 1'b1) begin bad++; $display("FAIL ioc_input_again got=%b exp=1", bus_a.ioc_flag); end
      $display("ioc masks/tris: flag=%b", bus_a.ioc_flag);
   endtask

   task automatic test_param8();
      bus_w.wr_tris = 1'b1; bus_w.wr_data = 8'h00; tick(); bus_w.wr_tris = 1'b0;
      bus_w.wr_port = 1'b1; bus_w.wr_op = 2'b00; bus_w.wr_data = 8'hA5; tick(); bus_w.wr_port = 1'b0;
      total++; if (bus_w.port_q !== 8'hA5 || pout_w !== 8'hA5 || poe_w !== 8'hFF) begin
         bad++; $display("FAIL w8_drive got port=%h out=%h oe=%h exp a5/a5/ff", bus_w.port_q, pout_w, poe_w);
      end
      tick();
      total++; if (bus_w.rd_data !== 8'h00) begin bad++; $display("FAIL w8_early got=%h exp=00", bus_w.rd_data); end
      tick();
      total++; if (bus_w.rd_data !== 8'hA5) begin bad++; $display("FAIL w8_readback got=%h exp=a5", bus_w.rd_data); end
      $display("width8 loopback: port=%h rd=%h", bus_w.port_q, bus_w.rd_data);
   endtask

   initial begin
      pin_a = '0; pin_c = '0;
      bus_a.wr_port = 0; bus_a.wr_tris = 0; bus_a.wr_op = 0; bus_a.wr_data = 0; bus_a.rd_port = 0; bus_a.ioc_clr = 0;
      bus_c.wr_port = 0; bus_c.wr_tris = 0; bus_c.wr_op = 0; bus_c.wr_data = 0; bus_c.rd_port = 0; bus_c.ioc_clr = 0;
      bus_w.wr_port = 0; bus_w.wr_tris = 0; bus_w.wr_op = 0; bus_w.wr_data = 0; bus_w.rd_port = 0; bus_w.ioc_clr = 0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      test_reset();
      test_bit_ops();
      test_sync();
      test_ioc();
      test_param8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Parametrised bidirectional GPIO port controller. Successor to the fixed 5-bit pass-through output port.
- Holds an output data latch and a TRIS direction register, and supports write/set/clear/toggle ops from the core.
- Synchronises pin inputs, supports open-drain bits (RA4-style), and raises an interrupt-on-change flag (RB4–RB7-style) for masked input pins.
- Sits between the file-register bus (PORTx/TRISx decode) and the pad ring.

Parameters:
- WIDTH, 5, number of port pins.
- OD_MASK, 5'b10000, bit=1 makes that pin open-drain (drives low only).
- IOC_MASK, 5'b00000, bit=1 enables interrupt-on-change for that pin.
- SYNC_STAGES, 2, input synchroniser depth (legal range 2..3).
- TRIS_RST, all ones, TRIS reset value (1 = input).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_port  input  1  write strobe for the port latch.
- wr_tris  input  1  write strobe for the TRIS register.
- wr_op  input  2  port write op: 00 load, 01 set bits, 10 clear bits, 11 toggle bits (TRIS is always load).
- wr_data  input  WIDTH  write data / bit mask.
- rd_port  input  1  port read strobe; updates the IOC snapshot.
- ioc_clr  input  1  clears ioc_flag.
- pin_in  input  WIDTH  pad input values (asynchronous).
- pin_out  output  WIDTH  pad output values.
- pin_oe  output  WIDTH  pad output enable (1 = drive).
- rd_data  output  WIDTH  synchronised pin values.
- port_q  output  WIDTH  output latch contents.
- tris_q  output  WIDTH  TRIS register contents.
- ioc_flag  output  1  sticky change interrupt flag.

Behaviour:
- Reset (async, immediate):
  - port_q = 0, tris_q = TRIS_RST.
  - All synchroniser stages = 0, snapshot = 0.
  - ioc_flag = 0, ioc_armed = 0.
  - Resulting outputs: pin_oe = ~TRIS_RST (all 0 by default), pin_out = 0.
  - Reset mid-operation discards any pending write or read.
- Port latch: on a clk edge with wr_port = 1, port_q becomes:
  - op 00: wr_data
  - op 01: port_q | wr_data
  - op 10: port_q & ~wr_data
  - op 11: port_q ^ wr_data
  - Write latency is 1 cycle: the new value is visible on port_q/pin_out after the edge.
- TRIS: on a clk edge with wr_tris = 1, tris_q becomes wr_data.
  - wr_port and wr_tris in the same cycle both take effect on the same edge.
- Pad drive (combinational from registers):
  - Push-pull bit i (OD_MASK[i] = 0): pin_oe[i] = ~tris_q[i]; pin_out[i] = port_q[i].
  - Open-drain bit i (OD_MASK[i] = 1): pin_out[i] = 0; pin_oe[i] = ~tris_q[i] & ~port_q[i].
- Input path:
  - pin_in passes through SYNC_STAGES flops to give sync_q; rd_data = sync_q.
  - A pin change is visible on rd_data exactly SYNC_STAGES edges later.
  - Output pins read back their pad value, not the latch value. Read-modify-write by the core therefore uses rd_data, as on silicon.
- Interrupt-on-change:
  - A rd_port edge loads snapshot <= sync_q and sets ioc_armed = 1.
  - Each edge: mismatch = ioc_armed & |(IOC_MASK & tris_q & (sync_q ^ snapshot)).
  - A mismatch sets ioc_flag. The flag stays set, even after the mismatch ends, until an ioc_clr edge.
  - ioc_clr and mismatch on the same edge: set wins; ioc_flag stays 1.
  - rd_port and ioc_clr on the same edge: snapshot updates and the flag clears. The mismatch for that edge is evaluated against the old snapshot, so the set-wins rule still applies.
  - Pins configured as outputs (tris = 0) never trigger.
  - Before the first rd_port after reset, no IOC is possible. This prevents spurious flags while the synchroniser fills.
- Width rules:
  - All ops are bitwise; there is no carry or overflow.
  - Mask parameters are truncated or zero-extended to WIDTH.

Test Plan:
- Reset and OE: assert rst mid-cycle with port_q = 5'h1F -> port_q = 0, tris_q = 5'h1F, pin_oe = 0 immediately. Then wr_tris 5'h00, wr_port op00 5'h15 -> next cycle pin_out = 5'h05, pin_oe = 5'h0F (bit4 open-drain released because port_q[4] = 1).
- Bit ops: port_q = 5'h0A. Apply op01 mask 5'h01 -> 5'h0B; op10 mask 5'h08 -> 5'h03; op11 mask 5'h1F -> 5'h1C, each after 1 edge. wr_port and wr_tris in the same cycle -> both registers update on that edge.
- Synchroniser latency: pin_in 5'h00 -> 5'h11 between edges -> rd_data = 5'h11 exactly on the 2nd edge (SYNC_STAGES = 2). Repeat with SYNC_STAGES = 3 -> 3rd edge.
- IOC (IOC_MASK = 5'h18, tris all 1): toggle pin3 before any rd_port -> ioc_flag stays 0. After rd_port, toggle pin3 -> ioc_flag = 1 at SYNC_STAGES + 1 edges. Toggling pin0 gives no flag. Setting tris[3] = 0 suppresses the pin3 trigger.
- IOC race: hold the pin3 mismatch and pulse ioc_clr -> flag stays 1. Pulse rd_port + ioc_clr together -> flag stays 1 on that edge; pulse ioc_clr again next cycle -> flag = 0 and stays 0.
- Parametrisation: WIDTH = 8, OD_MASK = 0 -> all bits push-pull; full load/readback of 8'hA5 through port_q and rd_data (with loopback pin_in = pin_out).
